// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM state encoding,
// instruction-word field positions and the sequential PC increment.
package fetch_pkg;

  typedef enum logic [1:0] {
    RESET_WAIT = 2'd0,
    REQ        = 2'd1,
    ISSUE      = 2'd2
  } fetch_state_t;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  localparam int PC_INC = 4;

endpackage

// File: rtl/pc_next_gen.sv
// Next fetch address: sequential pc+4 (wrapping) or the word-aligned branch target.
module pc_next_gen
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] seq_addr;
  logic [ADDR_W-1:0] br_addr;

  assign seq_addr  = pc + ADDR_W'(PC_INC);
  // Low two bits of the target are discarded so every fetch stays word aligned.
  assign br_addr   = branch_target & ~ADDR_W'(3);
  assign next_addr = branch_taken ? br_addr : seq_addr;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch sequencer: PC, req/ack fetch from instruction memory, IR and decoded fields.
// Optional ack watchdog enabled by defining FETCH_TIMEOUT_EN.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [5:0]        op,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [5:0]        funct,
  output logic [15:0]       imm,
  output logic              fetch_err
);

  fetch_state_t      state_reg, state_next;
  logic              started_reg;
  logic [ADDR_W-1:0] fetch_addr_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [31:0]       ir_reg;
  logic [ADDR_W-1:0] next_addr;
  logic              req_hold;
  logic              accept;

  assign accept = (state_reg == REQ) && imem_ack && !req_hold;

  // started_reg keeps the FSM in RESET_WAIT for one full cycle after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= RESET_WAIT;
      started_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      started_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RESET_WAIT: if (started_reg) state_next = REQ;
      REQ:        if (accept)      state_next = ISSUE;
      ISSUE:      if (!stall)      state_next = REQ;
      default:    state_next = RESET_WAIT;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_reg)
      REQ:     imem_req    = !req_hold;
      ISSUE:   instr_valid = 1'b1;
      default: ;
    endcase
  end

  pc_next_gen #(
    .ADDR_W(ADDR_W)
  ) u_pc_next_gen (
    .pc            (pc_reg),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .next_addr     (next_addr)
  );

  // The redirect decision is taken only on the cycle that leaves ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr_reg <= RESET_PC;
      pc_reg         <= RESET_PC;
      ir_reg         <= '0;
    end else if (accept) begin
      ir_reg <= imem_rdata;
      pc_reg <= fetch_addr_reg;
    end else if (state_reg == ISSUE && !stall) begin
      fetch_addr_reg <= next_addr;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] wait_cnt_reg;
  logic             drop_reg;
  logic             err_reg;

  // On expiry the request drops for one cycle, then the same address is re-requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg <= '0;
      drop_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      drop_reg <= 1'b0;
      if (state_reg == REQ && !drop_reg) begin
        if (imem_ack) begin
          wait_cnt_reg <= '0;
        end else if (wait_cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) begin
          wait_cnt_reg <= '0;
          drop_reg     <= 1'b1;
          err_reg      <= 1'b1;
        end else begin
          wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign req_hold  = drop_reg;
  assign fetch_err = err_reg;
`else
  assign req_hold  = 1'b0;
  // Without the watchdog the fault flag is a constant 0 for any legal TIMEOUT_CYC.
  assign fetch_err = (TIMEOUT_CYC < 0);
`endif

  assign imem_addr = fetch_addr_reg;
  assign pc        = pc_reg;
  assign op        = ir_reg[OP_MSB:OP_LSB];
  assign rs        = ir_reg[RS_MSB:RS_LSB];
  assign rt        = ir_reg[RT_MSB:RT_LSB];
  assign rd        = ir_reg[RD_MSB:RD_LSB];
  assign funct     = ir_reg[FUNCT_MSB:FUNCT_LSB];
  assign imm       = ir_reg[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed table, randomized transactions
// against a transaction-level address model, reset and wrap corner cases.
module tb_instruction_fetch;

  localparam int TO = 16;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        instr_valid;
  logic [31:0] pc;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic        fetch_err;

  logic        rst_n_w;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_pc;
  logic [5:0]  w_op;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [5:0]  w_funct;
  logic [15:0] w_imm;
  logic        w_err;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_word = '0;
  logic        exp_err = 1'b0;

  instruction_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_valid(instr_valid), .pc(pc), .op(op), .rs(rs), .rt(rt), .rd(rd),
    .funct(funct), .imm(imm), .fetch_err(fetch_err)
  );

  // Second instance: reset PC at the top of the address space, zero-wait memory.
  instruction_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .TIMEOUT_CYC(TO)) dut_wrap (
    .clk(clk), .rst_n(rst_n_w), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_req), .imem_rdata(32'h1234_5678), .stall(1'b0),
    .branch_taken(1'b0), .branch_target(32'h0),
    .instr_valid(w_valid), .pc(w_pc), .op(w_op), .rs(w_rs), .rt(w_rt), .rd(w_rd),
    .funct(w_funct), .imm(w_imm), .fetch_err(w_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got still running, expected finished");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fields(input string tag, input logic [31:0] word);
    chk({tag, "_op"},    32'(op),    word >> 26);
    chk({tag, "_rs"},    32'(rs),    (word >> 21) & 32'h1F);
    chk({tag, "_rt"},    32'(rt),    (word >> 16) & 32'h1F);
    chk({tag, "_rd"},    32'(rd),    (word >> 11) & 32'h1F);
    chk({tag, "_funct"}, 32'(funct), word & 32'h3F);
    chk({tag, "_imm"},   32'(imm),   word & 32'hFFFF);
  endtask

  // One full transaction: request (with waits), issue (with stalls), exit decision.
  task automatic fetch_one(input int waits, input int stalls, input logic br,
                           input logic [31:0] tgt, input logic [31:0] word,
                           input logic [31:0] exp_pc, input logic [31:0] exp_next);
    chk("req_start", 32'(imem_req), 32'd1);
    chk("addr_start", imem_addr, exp_pc);
    for (int w = 0; w < waits; w++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      step();
      chk("req_wait", 32'(imem_req), 32'd1);
      chk("addr_wait", imem_addr, exp_pc);
      chk("valid_wait", 32'(instr_valid), 32'd0);
      chk("ir_hold_wait", {op, rs, rt, rd, funct, imm}, 32'd0 | {last_word[31:11], last_word[5:0], last_word[15:0]});
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    step();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    last_word  = word;
    chk("valid_issue", 32'(instr_valid), 32'd1);
    chk("pc_issue", pc, exp_pc);
    chk("req_issue", 32'(imem_req), 32'd0);
    chk_fields("issue", word);
    for (int s = 0; s < stalls; s++) begin
      stall         = 1'b1;
      branch_taken  = (s == stalls / 2);
      branch_target = $urandom;
      imem_ack      = 1'($urandom_range(0, 1));
      step();
      chk("valid_stall", 32'(instr_valid), 32'd1);
      chk("pc_stall", pc, exp_pc);
      chk("req_stall", 32'(imem_req), 32'd0);
      chk_fields("stall", word);
    end
    stall         = 1'b0;
    imem_ack      = 1'b0;
    branch_taken  = br;
    branch_target = tgt;
    step();
    branch_taken = 1'b0;
    chk("next_addr", imem_addr, exp_next);
    chk("valid_after", 32'(instr_valid), 32'd0);
    chk("fetch_err", 32'(fetch_err), 32'(exp_err));
  endtask

  typedef struct {
    int          waits;
    int          stalls;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] word;
    logic [31:0] exp_pc;
    logic [31:0] exp_next;
  } vec_t;

  vec_t        tbl[5];
  logic [31:0] model_pc;
  logic [31:0] model_next;

  initial begin
    tbl[0] = '{0, 0, 1'b0, 32'h0,         32'h0000_0020, 32'h0,   32'h4};
    tbl[1] = '{3, 0, 1'b0, 32'h0,         32'h8C22_0004, 32'h4,   32'h8};
    tbl[2] = '{0, 5, 1'b0, 32'h0,         32'h0043_2820, 32'h8,   32'hC};
    tbl[3] = '{0, 0, 1'b1, 32'h0000_0103, 32'h1000_FFFF, 32'hC,   32'h100};
    tbl[4] = '{2, 1, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h100, 32'hFFFF_FFFC};

    rst_n = 1'b0; rst_n_w = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    repeat (2) step();

    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    chk_fields("rst", 32'h0);

    rst_n = 1'b1;
    step();
    chk("edge1_req", 32'(imem_req), 32'd0);
    step();
    chk("edge2_req", 32'(imem_req), 32'd1);

    for (int i = 0; i < 5; i++)
      fetch_one(tbl[i].waits, tbl[i].stalls, tbl[i].br, tbl[i].tgt, tbl[i].word,
                tbl[i].exp_pc, tbl[i].exp_next);

    // Random traffic; expected address stream is next = branch ? target&~3 : cur+4.
    model_pc = 32'hFFFF_FFFC;
    for (int t = 0; t < 30; t++) begin
      int          waits;
      int          stalls;
      logic        br;
      logic [31:0] tgt;
      logic [31:0] word;
      waits  = $urandom_range(0, 4);
      stalls = $urandom_range(0, 3);
      br     = ($urandom_range(0, 3) == 0);
      tgt    = $urandom;
      word   = $urandom;
      model_next = br ? (tgt & ~32'h3) : model_pc + 32'd4;
      fetch_one(waits, stalls, br, tgt, word, model_pc, model_next);
      model_pc = model_next;
    end

    // Asynchronous reset while a request is outstanding, then a late ack.
    imem_ack = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", 32'(imem_req), 32'd0);
    chk("async_addr", imem_addr, 32'h0);
    chk("async_pc", pc, 32'h0);
    chk("async_valid", 32'(instr_valid), 32'd0);
    chk_fields("async", 32'h0);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("late_ack_e1_req", 32'(imem_req), 32'd0);
    chk("late_ack_e1_valid", 32'(instr_valid), 32'd0);
    step();
    chk("late_ack_e2_valid", 32'(instr_valid), 32'd0);
    chk("late_ack_e2_pc", pc, 32'h0);
    chk_fields("late_ack", 32'h0);
    imem_ack  = 1'b0;
    last_word = '0;
    fetch_one(1, 0, 1'b0, 32'h0, 32'hA5A5_5A5A, 32'h0, 32'h4);

`ifdef FETCH_TIMEOUT_EN
    imem_ack = 1'b0;
    for (int i = 1; i <= TO; i++) begin
      step();
      if (i < TO) begin
        chk("to_req_wait", 32'(imem_req), 32'd1);
        chk("to_err_wait", 32'(fetch_err), 32'd0);
      end else begin
        chk("to_req_drop", 32'(imem_req), 32'd0);
        chk("to_err_set", 32'(fetch_err), 32'd1);
        chk("to_addr_drop", imem_addr, 32'h4);
      end
    end
    step();
    chk("to_rereq", 32'(imem_req), 32'd1);
    chk("to_rereq_addr", imem_addr, 32'h4);
    exp_err = 1'b1;
    fetch_one(0, 1, 1'b0, 32'h0, 32'h2001_0007, 32'h4, 32'h8);
`endif

    // Reset PC at 0xFFFF_FFFC: sequential fetch after the first issue wraps to 0.
    chk("wrap_rst_addr", w_addr, 32'hFFFF_FFFC);
    chk("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);
    chk("wrap_rst_fields", {w_op, w_rs, w_rt, w_rd, w_funct, w_imm, w_err}, 32'h0 | 49'h0);
    rst_n_w = 1'b1;
    step();
    chk("wrap_e1_req", 32'(w_req), 32'd0);
    step();
    chk("wrap_e2_req", 32'(w_req), 32'd1);
    chk("wrap_e2_addr", w_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_issue_valid", 32'(w_valid), 32'd1);
    chk("wrap_issue_pc", w_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_next_req", 32'(w_req), 32'd1);
    chk("wrap_next_addr", w_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
